// File: rtl/cube_line_seq_if.sv
// Segment stream from cube_line_seq to the line rasteriser: one edge per
// valid/ready handshake, with endpoints, edge index and colour.
interface cube_line_seq_if #(
  parameter int XY_BITW = 16,
  parameter int COLORW  = 3
);
  logic               seg_valid;
  logic               seg_ready;
  logic [3:0]         seg_id;
  logic [XY_BITW-1:0] x0;
  logic [XY_BITW-1:0] y0;
  logic [XY_BITW-1:0] x1;
  logic [XY_BITW-1:0] y1;
  logic [COLORW-1:0]  color;

  modport master (
    output seg_valid, seg_id, x0, y0, x1, y1, color,
    input  seg_ready
  );

  modport slave (
    input  seg_valid, seg_id, x0, y0, x1, y1, color,
    output seg_ready
  );
endinterface

// File: rtl/cube_line_seq.sv
// Latches an origin and cuboid dimensions on start, registers the eight oblique
// corners once, then streams the twelve wireframe edges over a valid/ready link.
// Define CUBE_SEQ_CLIP_EN to saturate coordinates to the screen instead of wrapping.
module cube_line_seq #(
  parameter int XY_BITW  = 16,
  parameter int DIMW     = 10,
  parameter int COLORW   = 3,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [XY_BITW-1:0] org_x,
  input  logic [XY_BITW-1:0] org_y,
  input  logic [DIMW-1:0]    dim_w,
  input  logic [DIMW-1:0]    dim_h,
  input  logic [DIMW-1:0]    dim_d,
  output logic               busy,
  output logic               done,
  cube_line_seq_if.master    seg
);

  typedef logic [XY_BITW:0]   sum_t;
  typedef logic [XY_BITW-1:0] coord_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

  // Corner indices: 0 FTL, 1 FBL, 2 FBR, 3 FTR, 4..7 the same on the back face.
  typedef struct packed {
    logic [2:0] src;
    logic [2:0] dst;
    logic [2:0] code;
  } edge_t;

  function automatic edge_t edge_lookup(input logic [3:0] id);
    edge_t e;
    case (id)
      4'd0:    e = '{src: 3'd0, dst: 3'd1, code: 3'd1};
      4'd1:    e = '{src: 3'd1, dst: 3'd2, code: 3'd2};
      4'd2:    e = '{src: 3'd2, dst: 3'd3, code: 3'd3};
      4'd3:    e = '{src: 3'd3, dst: 3'd0, code: 3'd4};
      4'd4:    e = '{src: 3'd4, dst: 3'd5, code: 3'd1};
      4'd5:    e = '{src: 3'd5, dst: 3'd6, code: 3'd2};
      4'd6:    e = '{src: 3'd6, dst: 3'd7, code: 3'd3};
      4'd7:    e = '{src: 3'd7, dst: 3'd4, code: 3'd4};
      4'd8:    e = '{src: 3'd0, dst: 3'd4, code: 3'd1};
      4'd9:    e = '{src: 3'd1, dst: 3'd5, code: 3'd2};
      4'd10:   e = '{src: 3'd3, dst: 3'd7, code: 3'd4};
      4'd11:   e = '{src: 3'd2, dst: 3'd6, code: 3'd3};
      default: e = '{src: 3'd0, dst: 3'd0, code: 3'd0};
    endcase
    return e;
  endfunction

  function automatic coord_t fit_x(input sum_t s);
`ifdef CUBE_SEQ_CLIP_EN
    if (s > sum_t'(SCREEN_W - 1)) return coord_t'(SCREEN_W - 1);
    return coord_t'(s);
`else
    return coord_t'(s);
`endif
  endfunction

  function automatic coord_t fit_y(input sum_t s);
`ifdef CUBE_SEQ_CLIP_EN
    if (s > sum_t'(SCREEN_H - 1)) return coord_t'(SCREEN_H - 1);
    return coord_t'(s);
`else
    return coord_t'(s);
`endif
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     seg_id_q, seg_id_d;
  logic           latch_en, load_en;
  coord_t         org_x_q, org_y_q;
  logic [DIMW-1:0] dim_w_q, dim_h_q, dim_d_q;
  coord_t         corner_x_q [8];
  coord_t         corner_y_q [8];
  coord_t         corner_x_d [8];
  coord_t         corner_y_d [8];

  // FSM next-state and control.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    seg_id_d = seg_id_q;
    latch_en = 1'b0;
    load_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        load_en = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (seg.seg_ready) begin
          if (seg_id_q == 4'd11) begin
            seg_id_d = 4'd0;
            state_d  = S_DONE;
          end else begin
            seg_id_d = seg_id_q + 4'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Corner arithmetic at XY_BITW+1 bits from the latched operands.
  always_comb begin
    sum_t fx_l, fx_r, fy_t, fy_b, d;
    d    = sum_t'(dim_d_q);
    fx_l = sum_t'(org_x_q);
    fx_r = fx_l + sum_t'(dim_w_q);
    fy_t = sum_t'(org_y_q);
    fy_b = fy_t + sum_t'(dim_h_q);
    corner_x_d[0] = fit_x(fx_l);
    corner_x_d[1] = fit_x(fx_l);
    corner_x_d[2] = fit_x(fx_r);
    corner_x_d[3] = fit_x(fx_r);
    corner_x_d[4] = fit_x(fx_l + d);
    corner_x_d[5] = fit_x(fx_l + d);
    corner_x_d[6] = fit_x(fx_r + d);
    corner_x_d[7] = fit_x(fx_r + d);
    corner_y_d[0] = fit_y(fy_t);
    corner_y_d[1] = fit_y(fy_b);
    corner_y_d[2] = fit_y(fy_b);
    corner_y_d[3] = fit_y(fy_t);
    corner_y_d[4] = fit_y(fy_t + d);
    corner_y_d[5] = fit_y(fy_b + d);
    corner_y_d[6] = fit_y(fy_b + d);
    corner_y_d[7] = fit_y(fy_t + d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= S_IDLE;
      seg_id_q <= '0;
      org_x_q  <= '0;
      org_y_q  <= '0;
      dim_w_q  <= '0;
      dim_h_q  <= '0;
      dim_d_q  <= '0;
      // NOTE: the corner array is tiny, so it is reset like any other register to keep X out of the datapath.
      for (int i = 0; i < 8; i++) begin
        corner_x_q[i] <= '0;
        corner_y_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      seg_id_q <= seg_id_d;
      if (latch_en) begin
        org_x_q <= org_x;
        org_y_q <= org_y;
        dim_w_q <= dim_w;
        dim_h_q <= dim_h;
        dim_d_q <= dim_d;
      end
      if (load_en) begin
        for (int i = 0; i < 8; i++) begin
          corner_x_q[i] <= corner_x_d[i];
          corner_y_q[i] <= corner_y_d[i];
        end
      end
    end
  end

  edge_t edge_cur;
  logic  emit;

  assign edge_cur = edge_lookup(seg_id_q);
  assign emit     = (state_q == S_EMIT);

  // Outputs decode straight from registers, so reset clears them without waiting for a clock.
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign seg.seg_valid = emit;
  assign seg.seg_id    = seg_id_q;
  assign seg.x0        = emit ? corner_x_q[edge_cur.src] : '0;
  assign seg.y0        = emit ? corner_y_q[edge_cur.src] : '0;
  assign seg.x1        = emit ? corner_x_q[edge_cur.dst] : '0;
  assign seg.y1        = emit ? corner_y_q[edge_cur.dst] : '0;
  assign seg.color     = emit ? COLORW'(edge_cur.code) : '0;

endmodule
